// File: rtl/operand_capture_fifo_if.sv
// Handshake bundle for operand_capture_fifo: decode side (in_*) and execute side (out_*).
// OPERAND_FWD_EN adds the forwarding signals fwd_valid/fwd_rd/fwd_data/in_rs_idx.
interface operand_capture_fifo_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                   in_valid;
  logic                   in_ready;
  logic [6:0]             in_opcode;
  logic [XLEN-1:0]        in_imm;
  logic [NSRC*XLEN-1:0]   in_rf_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [6:0]             out_opcode;
  logic [1:0]             out_class;
  logic [NSRC*XLEN-1:0]   out_operands;
  logic [CW-1:0]          out_count;
`ifdef OPERAND_FWD_EN
  logic                   fwd_valid;
  logic [4:0]             fwd_rd;
  logic [XLEN-1:0]        fwd_data;
  logic [NSRC*5-1:0]      in_rs_idx;

  modport master (
    output in_valid, in_opcode, in_imm, in_rf_data, out_ready,
    output fwd_valid, fwd_rd, fwd_data, in_rs_idx,
    input  in_ready, out_valid, out_opcode, out_class, out_operands, out_count
  );
  modport slave (
    input  in_valid, in_opcode, in_imm, in_rf_data, out_ready,
    input  fwd_valid, fwd_rd, fwd_data, in_rs_idx,
    output in_ready, out_valid, out_opcode, out_class, out_operands, out_count
  );
`else
  modport master (
    output in_valid, in_opcode, in_imm, in_rf_data, out_ready,
    input  in_ready, out_valid, out_opcode, out_class, out_operands, out_count
  );
  modport slave (
    input  in_valid, in_opcode, in_imm, in_rf_data, out_ready,
    output in_ready, out_valid, out_opcode, out_class, out_operands, out_count
  );
`endif
endinterface

// File: rtl/operand_capture_fifo.sv
// Operand-capture stage: classifies opcodes, selects NSRC operands and buffers bundles in a DEPTH-entry FIFO.
// Define OPERAND_FWD_EN to enable register-file bypass from the fwd_* signals.
module operand_capture_fifo #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned DEPTH = 2
) (
  input logic                  clk,
  input logic                  rst,
  operand_capture_fifo_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    CLS_NONE = 2'b00,
    CLS_I    = 2'b01,
    CLS_R    = 2'b10
  } op_class_e;

  typedef struct packed {
    logic [6:0]           opcode;
    op_class_e            cls;
    logic [NSRC*XLEN-1:0] operands;
  } bundle_t;

  bundle_t       mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  op_class_e       cls;
  bundle_t         cap;
  bundle_t         head;
  logic [XLEN-1:0] rf_sel;
  logic            is_i, is_r;
  logic            full, not_empty, push, pop;

  always_comb begin
    is_i = (bus.in_opcode[6:3] == 4'b0000) || (bus.in_opcode[6:4] == 3'b001) ||
           (bus.in_opcode[6:2] == 5'b11001);
    is_r = (bus.in_opcode[6:4] == 3'b011) || (bus.in_opcode[6:2] == 5'b01011) ||
           (bus.in_opcode[6:2] == 5'b10100);
    if (is_i)      cls = CLS_I;
    else if (is_r) cls = CLS_R;
    else           cls = CLS_NONE;
  end

  // Channel 0 always reads the register file when classified; higher channels take the immediate for I-type.
  always_comb begin
    cap          = '0;
    rf_sel       = '0;
    cap.opcode   = bus.in_opcode;
    cap.cls      = cls;
    for (int unsigned k = 0; k < NSRC; k++) begin
      rf_sel = bus.in_rf_data[k*XLEN +: XLEN];
`ifdef OPERAND_FWD_EN
      if (bus.fwd_valid && (bus.fwd_rd != 5'd0) && (bus.fwd_rd == bus.in_rs_idx[k*5 +: 5]))
        rf_sel = bus.fwd_data;
`endif
      if ((cls == CLS_R) || ((cls == CLS_I) && (k == 0)))
        cap.operands[k*XLEN +: XLEN] = rf_sel;
      else if (cls == CLS_I)
        cap.operands[k*XLEN +: XLEN] = bus.in_imm;
    end
  end

  assign full      = (count_q == CW'(DEPTH));
  assign not_empty = (count_q != '0);
  assign push      = bus.in_valid & bus.in_ready;
  assign pop       = not_empty & bus.out_ready;

  // Pointers are PW bits wide, so DEPTH being a power of two makes the increment wrap by itself.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cap;
  end

  assign head             = mem_q[rd_ptr_q];
  assign bus.in_ready     = rst & ~full;
  assign bus.out_valid    = not_empty;
  assign bus.out_opcode   = not_empty ? head.opcode   : '0;
  assign bus.out_class    = not_empty ? head.cls      : CLS_NONE;
  assign bus.out_operands = not_empty ? head.operands : '0;
  assign bus.out_count    = count_q;
endmodule

// File: tb/tb_operand_capture_fifo.sv
// Scoreboard bench for operand_capture_fifo: directed scenarios followed by randomized traffic and resets.
module tb_operand_capture_fifo;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NSRC  = 2;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned W     = NSRC * XLEN;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_capture_fifo_if #(.XLEN(XLEN), .NSRC(NSRC), .DEPTH(DEPTH)) bus ();
  operand_capture_fifo #(.XLEN(XLEN), .NSRC(NSRC), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [6:0] op;
    logic [1:0] cls;
    logic [W-1:0] opnds;
  } exp_t;

  exp_t sb[$];
  exp_t exp_n;
  logic acc_n = 1'b0;
  logic pop_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   dut_xfers = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: operands derived straight from the classification rules.
  function automatic exp_t model(input logic [6:0] op, input logic [XLEN-1:0] imm,
                                 input logic [W-1:0] rf);
    exp_t e;
    logic is_i, is_r;
    logic [XLEN-1:0] rv;
    is_i = (op ==? 7'b0000???) || (op ==? 7'b001????) || (op ==? 7'b11001??);
    is_r = (op ==? 7'b011????) || (op ==? 7'b01011??) || (op ==? 7'b10100??);
    e.op    = op;
    e.cls   = is_i ? 2'b01 : (is_r ? 2'b10 : 2'b00);
    e.opnds = '0;
    for (int k = 0; k < NSRC; k++) begin
      rv = rf[k*XLEN +: XLEN];
`ifdef OPERAND_FWD_EN
      if (bus.fwd_valid && bus.fwd_rd != 0 && bus.fwd_rd == bus.in_rs_idx[k*5 +: 5])
        rv = bus.fwd_data;
`endif
      if (is_i)      e.opnds[k*XLEN +: XLEN] = (k == 0) ? rv : imm;
      else if (is_r) e.opnds[k*XLEN +: XLEN] = rv;
    end
    return e;
  endfunction

  // Issue side: decide acceptance from the model's own occupancy.
  always @(negedge clk) begin
    acc_n = bus.in_valid && rst && (sb.size() < DEPTH);
    if (acc_n) exp_n = model(bus.in_opcode, bus.in_imm, bus.in_rf_data);
  end

  // Monitor: compare DUT outputs against the scoreboard head.
  always @(negedge clk) begin
    int unsigned n;
    n = sb.size();
    check("out_count", W'(bus.out_count), W'(n));
    check("out_valid", W'(bus.out_valid), W'(n != 0));
    check("in_ready", W'(bus.in_ready), W'(rst && n < DEPTH));
    if (n != 0) begin
      check("head_opcode", W'(bus.out_opcode), W'(sb[0].op));
      check("head_class", W'(bus.out_class), W'(sb[0].cls));
      check("head_operands", bus.out_operands, sb[0].opnds);
    end else begin
      check("empty_head", W'(bus.out_opcode) | W'(bus.out_class) | bus.out_operands, '0);
    end
    pop_n = (n != 0) && bus.out_ready && rst;
    if (bus.out_valid && bus.out_ready) dut_xfers++;
  end

  always @(posedge clk) begin
    if (!rst) sb.delete();
    else begin
      if (pop_n) void'(sb.pop_front());
      if (acc_n) sb.push_back(exp_n);
    end
    pop_n = 1'b0;
    acc_n = 1'b0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [XLEN-1:0] imm,
                       input logic [W-1:0] rf, input logic ordy);
    bus.in_valid   = v;
    bus.in_opcode  = op;
    bus.in_imm     = imm;
    bus.in_rf_data = rf;
    bus.out_ready  = ordy;
  endtask

  logic [6:0] ops [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                          7'b0101111, 7'b1010011, 7'b1111111, 7'b0100011};

  initial begin
    int x0;
    rst = 1'b0;
`ifdef OPERAND_FWD_EN
    bus.fwd_valid = 1'b0;
    bus.fwd_rd    = '0;
    bus.fwd_data  = '0;
    bus.in_rs_idx = '0;
`endif
    // Reset held with in_valid asserted
    drive(1'b1, 7'b0110011, 32'h1234, {32'h5, 32'h6}, 1'b0);
    step();
    step();
    check("rst_in_ready", W'(bus.in_ready), '0);
    check("rst_count", W'(bus.out_count), '0);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("release_in_ready", W'(bus.in_ready), W'(1));

    // R-type held until out_ready
    drive(1'b1, 7'b0110011, 32'hDEAD, {32'h22, 32'h11}, 1'b0);
    step();
    bus.in_valid = 1'b0;
    check("r_valid", W'(bus.out_valid), W'(1));
    check("r_class", W'(bus.out_class), W'(2'b10));
    check("r_ops", bus.out_operands, {32'h22, 32'h11});
    repeat (3) step();
    check("r_hold", bus.out_operands, {32'h22, 32'h11});
    bus.out_ready = 1'b1;
    step();
    check("r_drained", W'(bus.out_valid), '0);

    // I-type and unclassified
    drive(1'b1, 7'b0010011, 32'hFFFFF800, {32'h77, 32'hA}, 1'b1);
    step();
    check("i_class", W'(bus.out_class), W'(2'b01));
    check("i_ops", bus.out_operands, {32'hFFFFF800, 32'h0000000A});
    drive(1'b1, 7'b1111111, 32'h1, {32'h3, 32'h4}, 1'b1);
    step();
    bus.in_valid = 1'b0;
    check("u_class", W'(bus.out_class), '0);
    check("u_ops", bus.out_operands, '0);
    check("u_valid", W'(bus.out_valid), W'(1));
    step();

    // Full: C must be refused
    drive(1'b1, 7'b0110011, 32'h0, {32'hA1, 32'hA0}, 1'b0);
    step();
    drive(1'b1, 7'b0010011, 32'hB1, {32'hB9, 32'hB0}, 1'b0);
    step();
    check("full_in_ready", W'(bus.in_ready), '0);
    drive(1'b1, 7'b0000011, 32'hC1, {32'hC9, 32'hC0}, 1'b0);
    repeat (2) step();
    check("full_count", W'(bus.out_count), W'(2));
    check("full_head", W'(bus.out_opcode), W'(7'b0110011));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("drain_second", W'(bus.out_opcode), W'(7'b0010011));
    step();
    check("drain_empty", W'(bus.out_valid), '0);

    // Streaming across pointer wrap
    x0 = dut_xfers;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, ops[i], 32'(i * 3 + 1), {32'(i + 100), 32'(i + 200)}, 1'b1);
      step();
      check("stream_count", W'(bus.out_count), W'(1));
    end
    bus.in_valid = 1'b0;
    step();
    check("stream_xfers", W'(dut_xfers - x0), W'(8));

    // Mid-operation reset
    drive(1'b1, 7'b0110011, 32'h0, {32'hE1, 32'hE0}, 1'b0);
    repeat (2) step();
    check("pre_rst_count", W'(bus.out_count), W'(2));
    rst = 1'b0;
    bus.in_valid = 1'b0;
    step();
    check("mid_rst_valid", W'(bus.out_valid), '0);
    check("mid_rst_count", W'(bus.out_count), '0);
    rst = 1'b1;
    drive(1'b1, 7'b0110111, 32'h0, {32'hD1, 32'hD0}, 1'b0);
    step();
    bus.in_valid = 1'b0;
    check("post_rst_count", W'(bus.out_count), W'(1));
    check("post_rst_head", bus.out_operands, {32'hD1, 32'hD0});
    bus.out_ready = 1'b1;
    step();

`ifdef OPERAND_FWD_EN
    bus.fwd_valid = 1'b1;
    bus.fwd_rd    = 5'd5;
    bus.fwd_data  = 32'hF00D;
    bus.in_rs_idx = {5'd5, 5'd3};
    drive(1'b1, 7'b0110011, 32'h0, {32'h12, 32'h34}, 1'b1);
    step();
    check("fwd_hit", bus.out_operands, {32'hF00D, 32'h34});
    bus.fwd_rd    = 5'd0;
    bus.in_rs_idx = {5'd0, 5'd0};
    step();
    bus.in_valid = 1'b0;
    check("fwd_x0", bus.out_operands, {32'h12, 32'h34});
    step();
`endif

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)],
            $urandom, {$urandom, $urandom}, ($urandom_range(0, 2) != 0));
`ifdef OPERAND_FWD_EN
      bus.fwd_valid = 1'($urandom);
      bus.fwd_rd    = 5'($urandom_range(0, 3));
      bus.fwd_data  = $urandom;
      bus.in_rs_idx = 10'($urandom_range(0, 1023)) & 10'b0001100011;
`endif
      rst = ($urandom_range(0, 49) != 0);
      step();
    end
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
